// File: rtl/unidade_controle_exp8.sv
// -----------------------------------------------------------------------------
// unidade_controle_exp8
//
// Moore controller for the memory-game datapath. After a start request it
// clears the counters, replays the stored sequence on the LEDs for the
// current round (one on/off pair per stored word, paced by the display
// timer), then collects the player's moves one at a time under a per-move
// timeout. The game ends in win, lose or timeout, and waits there for a
// restart.
//
// Ports
//   clock                in   system clock, rising edge
//   reset                in   asynchronous reset, active low (0 = reset)
//   iniciar              in   start/restart request (level)
//   fimT                 in   display timer at terminal count
//   fimP                 in   move-timeout counter at terminal count
//   fimRod               in   round counter at last round
//   jogada               in   one-cycle pulse: button press detected
//   igual                in   registered move equals memory word
//   enderecoIgualRodada  in   address counter equals round counter
//   zeraE / contaE       out  clear / increment address counter
//   zeraRod / contaRod   out  clear / increment round counter
//   zeraT / contaT       out  clear / enable display timer
//   zeraP / contaP       out  clear / enable move-timeout counter
//   zeraR / registraR    out  clear / load move register
//   sinal_led            out  LEDs show memory word at current address
//   pronto               out  game finished
//   acertou              out  game won
//   errou                out  wrong move
//   timeout              out  move timeout expired
//   db_estado            out  current state code (debug)
// -----------------------------------------------------------------------------
module unidade_controle_exp8 (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimT,
  input  logic       fimP,
  input  logic       fimRod,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraP,
  output logic       contaP,
  output logic       zeraR,
  output logic       registraR,
  output logic       sinal_led,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  // State codes are visible on db_estado, so the encoding is fixed.
  typedef enum logic [3:0] {
    inicial        = 4'h0,
    preparacao     = 4'h1,
    inicia_rodada  = 4'h2,
    mostra_led     = 4'h3,
    apaga_led      = 4'h4,
    proximo_led    = 4'h5,
    fim_exibicao   = 4'h6,
    espera_jogada  = 4'h7,
    registra       = 4'h8,
    comparacao     = 4'h9,
    proxima_jogada = 4'hA,
    proxima_rodada = 4'hB,
    fim_acertou    = 4'hC,
    fim_errou      = 4'hD,
    fim_timeout    = 4'hE,
    ilegal         = 4'hF
  } estado_t;

  estado_t estado_reg;
  estado_t estado_next;

  // ---------------------------------------------------------------------------
  // State register. Reset is asynchronous so that pulling reset low mid-game
  // drops every strobe (outputs are pure decodes of this register) without
  // waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_reg <= inicial;
    end else begin
      estado_reg <= estado_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and Moore output decode.
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_next = estado_reg;
    zeraE       = 1'b0;
    contaE      = 1'b0;
    zeraRod     = 1'b0;
    contaRod    = 1'b0;
    zeraT       = 1'b0;
    contaT      = 1'b0;
    zeraP       = 1'b0;
    contaP      = 1'b0;
    zeraR       = 1'b0;
    registraR   = 1'b0;
    sinal_led   = 1'b0;
    pronto      = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    timeout     = 1'b0;

    case (estado_reg)
      inicial: begin
        if (iniciar) estado_next = preparacao;
      end

      // Clear everything for a fresh game.
      preparacao: begin
        zeraE       = 1'b1;
        zeraRod     = 1'b1;
        zeraR       = 1'b1;
        zeraT       = 1'b1;
        zeraP       = 1'b1;
        estado_next = inicia_rodada;
      end

      // Replay always starts from address 0 with the timer at 0, so the
      // first on-phase has the full timer period.
      inicia_rodada: begin
        zeraE       = 1'b1;
        zeraT       = 1'b1;
        estado_next = mostra_led;
      end

      // On-phase. The timer is modulo, so it wraps to 0 as we leave and the
      // off-phase gets an equally long period without an explicit clear.
      mostra_led: begin
        sinal_led = 1'b1;
        contaT    = 1'b1;
        if (fimT) estado_next = apaga_led;
      end

      // Off-phase. At its end either the replay covered every word of this
      // round, or we step to the next address.
      apaga_led: begin
        contaT = 1'b1;
        if (fimT) begin
          if (enderecoIgualRodada) estado_next = fim_exibicao;
          else                     estado_next = proximo_led;
        end
      end

      proximo_led: begin
        contaE      = 1'b1;
        estado_next = mostra_led;
      end

      // Rewind the address for the player's moves and arm the timeout.
      fim_exibicao: begin
        zeraE       = 1'b1;
        zeraP       = 1'b1;
        zeraR       = 1'b1;
        estado_next = espera_jogada;
      end

      // A press in the same cycle as the timeout still counts as a move.
      espera_jogada: begin
        contaP = 1'b1;
        if (jogada)    estado_next = registra;
        else if (fimP) estado_next = fim_timeout;
      end

      // Capture the move and restart the timeout for the next one.
      registra: begin
        registraR   = 1'b1;
        zeraP       = 1'b1;
        estado_next = comparacao;
      end

      // igual is valid here: the move register loaded on the previous edge.
      comparacao: begin
        if (!igual)                             estado_next = fim_errou;
        else if (enderecoIgualRodada && fimRod) estado_next = fim_acertou;
        else if (enderecoIgualRodada)           estado_next = proxima_rodada;
        else                                    estado_next = proxima_jogada;
      end

      proxima_jogada: begin
        contaE      = 1'b1;
        estado_next = espera_jogada;
      end

      proxima_rodada: begin
        contaRod    = 1'b1;
        estado_next = inicia_rodada;
      end

      fim_acertou: begin
        pronto  = 1'b1;
        acertou = 1'b1;
        if (iniciar) estado_next = preparacao;
      end

      fim_errou: begin
        pronto = 1'b1;
        errou  = 1'b1;
        if (iniciar) estado_next = preparacao;
      end

      fim_timeout: begin
        pronto  = 1'b1;
        timeout = 1'b1;
        if (iniciar) estado_next = preparacao;
      end

      // Code F is unreachable in normal operation; recover to idle.
      default: begin
        estado_next = inicial;
      end
    endcase
  end

  assign db_estado = estado_reg;

endmodule

// File: tb/tb_unidade_controle_exp8.sv
module tb_unidade_controle_exp8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, fimP = 1'b0, jogada = 1'b0, igual = 1'b0;
  logic fimT_drv = 1'b0, fimRod_drv = 1'b0, eir_drv = 1'b0;
  logic fimT, fimRod, enderecoIgualRodada;
  logic zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraP, contaP;
  logic zeraR, registraR, sinal_led, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int total = 0;
  int bad   = 0;

  // Behavioural datapath: display timer (mod 4), address and round counters.
  bit use_dp = 1'b0;
  int t = 0, e = 0, rnd = 0;
  int fix_round = -1;
  int last_round = 2;

  assign fimT = use_dp ? (t == 3) : fimT_drv;
  assign fimRod = use_dp ? (rnd == last_round) : fimRod_drv;
  assign enderecoIgualRodada = use_dp ? (e == ((fix_round >= 0) ? fix_round : rnd)) : eir_drv;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (zeraT) t <= 0;
    else if (contaT) t <= (t == 3) ? 0 : t + 1;
    if (zeraE) e <= 0;
    else if (contaE) e <= e + 1;
    if (zeraRod) rnd <= 0;
    else if (contaRod) rnd <= rnd + 1;
  end

  unidade_controle_exp8 dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimT(fimT), .fimP(fimP),
    .fimRod(fimRod), .jogada(jogada), .igual(igual),
    .enderecoIgualRodada(enderecoIgualRodada),
    .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
    .zeraT(zeraT), .contaT(contaT), .zeraP(zeraP), .contaP(contaP),
    .zeraR(zeraR), .registraR(registraR), .sinal_led(sinal_led),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  // Output vector bit positions.
  localparam int ZE = 14, CE = 13, ZROD = 12, CROD = 11, ZT = 10, CT = 9, ZP = 8, CP = 7;
  localparam int ZR = 6, RR = 5, LED = 4, PR = 3, AC = 2, ER = 1, TO = 0;

  logic [14:0] dut_outs;
  assign dut_outs = {zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraP, contaP,
                     zeraR, registraR, sinal_led, pronto, acertou, errou, timeout};

  logic [14:0] out_tab [16];

  // Expected asserted strobes per state, listed by name.
  task automatic init_tab();
    for (int s = 0; s < 16; s++) out_tab[s] = '0;
    out_tab[1][ZE] = 1; out_tab[1][ZROD] = 1; out_tab[1][ZR] = 1; out_tab[1][ZT] = 1; out_tab[1][ZP] = 1;
    out_tab[2][ZE] = 1; out_tab[2][ZT] = 1;
    out_tab[3][LED] = 1; out_tab[3][CT] = 1;
    out_tab[4][CT] = 1;
    out_tab[5][CE] = 1;
    out_tab[6][ZE] = 1; out_tab[6][ZP] = 1; out_tab[6][ZR] = 1;
    out_tab[7][CP] = 1;
    out_tab[8][RR] = 1; out_tab[8][ZP] = 1;
    out_tab[10][CE] = 1;
    out_tab[11][CROD] = 1;
    out_tab[12][PR] = 1; out_tab[12][AC] = 1;
    out_tab[13][PR] = 1; out_tab[13][ER] = 1;
    out_tab[14][PR] = 1; out_tab[14][TO] = 1;
  endtask

  // Reference next state from the game rules. in = {ini,fimT,fimP,fimRod,jogada,igual,eir}
  function automatic int nxt(int s, bit [6:0] in);
    bit ini = in[6], ft = in[5], fp = in[4], fr = in[3], jg = in[2], ig = in[1], eir = in[0];
    if (s == 0) return ini ? 1 : 0;
    if (s == 1) return 2;
    if (s == 2) return 3;
    if (s == 3) return ft ? 4 : 3;
    if (s == 4) return !ft ? 4 : (eir ? 6 : 5);
    if (s == 5) return 3;
    if (s == 6) return 7;
    if (s == 7) return jg ? 8 : (fp ? 14 : 7);
    if (s == 8) return 9;
    if (s == 9) begin
      if (!ig) return 13;
      if (eir && fr) return 12;
      if (eir) return 11;
      return 10;
    end
    if (s == 10) return 7;
    if (s == 11) return 2;
    if (s >= 12 && s <= 14) return ini ? 1 : s;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit [6:0] v);
    iniciar = v[6]; fimT_drv = v[5]; fimP = v[4]; fimRod_drv = v[3];
    jogada = v[2]; igual = v[1]; eir_drv = v[0];
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
  endtask

  // Observation counters for the multi-cycle sequences.
  int led_cyc, led_pulses, st4_cyc, ce5, crod;
  bit prev_led;
  logic [3:0] trace [$];

  task automatic clear_counts();
    led_cyc = 0; led_pulses = 0; st4_cyc = 0; ce5 = 0; crod = 0; prev_led = 0;
    trace.delete();
  endtask

  function automatic logic [3:0] tr(int i);
    if (i < trace.size()) return trace[i];
    return 4'hF;
  endfunction

  // Run until db_estado==target (sampled at negedge), optionally pressing a
  // button each time the FSM waits for a move.
  task automatic observe(input logic [3:0] target, input int bound, input bit auto_jog, output bit ok);
    ok = 0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clock);
      iniciar = 1'b0;
      trace.push_back(db_estado);
      if (sinal_led) begin
        led_cyc++;
        if (!prev_led) led_pulses++;
      end
      prev_led = sinal_led;
      if (db_estado == 4'h4) st4_cyc++;
      if (db_estado == 4'h5 && contaE) ce5++;
      if (contaRod) crod++;
      if (db_estado == target) begin
        ok = 1;
        break;
      end
      jogada = auto_jog && (db_estado == 4'h7);
    end
    jogada = 1'b0;
  endtask

  typedef struct {
    bit [6:0]   in;
    logic [3:0] st;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input bit [6:0] in, input logic [3:0] st);
    vec_t v;
    v.in = in; v.st = st;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit [6:0] rin;
    int m;

    init_tab();

    // ---------------- reset state ----------------
    #2;
    check("reset_state", db_estado, 0);
    check("reset_outs", dut_outs, 0);
    @(negedge clock); reset = 1'b1;

    // ---------------- table-driven walk ----------------
    add(7'b0000000, 4'h0); add(7'b1000000, 4'h1); add(7'b0000000, 4'h2); add(7'b0000000, 4'h3);
    add(7'b0000000, 4'h3); add(7'b0100000, 4'h4); add(7'b0000001, 4'h4); add(7'b0100000, 4'h5);
    add(7'b0000000, 4'h3); add(7'b0100000, 4'h4); add(7'b0100001, 4'h6); add(7'b0000000, 4'h7);
    add(7'b0000000, 4'h7); add(7'b0010100, 4'h8); add(7'b0000000, 4'h9); add(7'b0000010, 4'hA);
    add(7'b0000000, 4'h7); add(7'b0000100, 4'h8); add(7'b0000000, 4'h9); add(7'b0000011, 4'hB);
    add(7'b1000000, 4'h2); add(7'b0000000, 4'h3); add(7'b0100000, 4'h4); add(7'b0100001, 4'h6);
    add(7'b0000000, 4'h7); add(7'b0000100, 4'h8); add(7'b1000000, 4'h9); add(7'b0001011, 4'hC);
    add(7'b0000000, 4'hC); add(7'b1000000, 4'h1); add(7'b0000000, 4'h2); add(7'b0000000, 4'h3);
    add(7'b0100000, 4'h4); add(7'b0100001, 4'h6); add(7'b0000100, 4'h7); add(7'b0010000, 4'hE);
    add(7'b0000000, 4'hE); add(7'b1000000, 4'h1); add(7'b0000000, 4'h2); add(7'b0000000, 4'h3);
    add(7'b0100000, 4'h4); add(7'b0100001, 4'h6); add(7'b0000000, 4'h7); add(7'b0000100, 4'h8);
    add(7'b0000000, 4'h9); add(7'b0001001, 4'hD); add(7'b0000000, 4'hD); add(7'b1000000, 4'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      set_in(vecs[i].in);
      @(posedge clock); #1;
      check($sformatf("vec%0d_state", i), db_estado, vecs[i].st);
      check($sformatf("vec%0d_outs", i), dut_outs, out_tab[vecs[i].st]);
    end
    @(negedge clock); set_in(7'b0);

    // ---------------- async reset from state 7 ----------------
    use_dp = 1'b1; fix_round = 0;
    do_reset();
    iniciar = 1'b1;
    clear_counts();
    observe(4'h7, 100, 0, ok);
    check("arst_reach7", ok, 1);
    #2; reset = 1'b0; #1;
    check("arst_state", db_estado, 0);
    check("arst_outs", dut_outs, 0);
    @(negedge clock); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check($sformatf("idle%0d_state", i), db_estado, 0);
    end

    // ---------------- round 0 display ----------------
    @(negedge clock); iniciar = 1'b1;
    clear_counts();
    observe(4'h6, 100, 0, ok);
    check("r0_reach6", ok, 1);
    check("r0_trace0", tr(0), 1);
    check("r0_trace1", tr(1), 2);
    check("r0_trace2", tr(2), 3);
    check("r0_led_cycles", led_cyc, 4);
    check("r0_off_cycles", st4_cyc, 4);
    @(negedge clock);
    check("r0_then7", db_estado, 7);

    // ---------------- round 2 replay ----------------
    fix_round = 2;
    do_reset();
    iniciar = 1'b1;
    clear_counts();
    observe(4'h6, 200, 0, ok);
    check("r2_reach6", ok, 1);
    check("r2_led_pulses", led_pulses, 3);
    check("r2_led_cycles", led_cyc, 12);
    check("r2_contaE", ce5, 2);

    // ---------------- correct full game (3 rounds) ----------------
    fix_round = -1; last_round = 2; igual = 1'b1; fimP = 1'b0;
    do_reset();
    iniciar = 1'b1;
    clear_counts();
    observe(4'hC, 2000, 1, ok);
    check("win_reachC", ok, 1);
    check("win_contaRod", crod, 2);
    check("win_pronto", pronto, 1);
    check("win_acertou", acertou, 1);
    check("win_errou", errou, 0);

    // ---------------- wrong move ----------------
    @(negedge clock); igual = 1'b0; iniciar = 1'b1;
    @(posedge clock); #1;
    check("restartC_state", db_estado, 1);
    clear_counts();
    observe(4'hD, 500, 1, ok);
    check("lose_reachD", ok, 1);
    check("lose_errou", errou, 1);
    check("lose_pronto", pronto, 1);
    @(negedge clock); iniciar = 1'b1;
    @(posedge clock); #1;
    check("restartD_state", db_estado, 1);
    check("restartD_zeras", {zeraE, zeraRod, zeraT, zeraP, zeraR}, 5'b11111);
    check("restartD_outs", dut_outs, out_tab[1]);

    // ---------------- timeout and priority ----------------
    clear_counts();
    observe(4'h7, 200, 0, ok);
    check("to_reach7", ok, 1);
    fimP = 1'b1;
    @(posedge clock); #1;
    check("to_state", db_estado, 14);
    check("to_timeout", timeout, 1);
    check("to_pronto", pronto, 1);
    @(negedge clock); fimP = 1'b0; iniciar = 1'b1;
    clear_counts();
    observe(4'h7, 200, 0, ok);
    check("prio_reach7", ok, 1);
    jogada = 1'b1; fimP = 1'b1;
    @(posedge clock); #1;
    check("prio_state", db_estado, 8);
    check("prio_registraR", registraR, 1);
    @(negedge clock); jogada = 1'b0; fimP = 1'b0;

    // ---------------- randomized vs reference model ----------------
    use_dp = 1'b0;
    do_reset();
    m = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      check("rnd_state", db_estado, m);
      check("rnd_outs", dut_outs, out_tab[m]);
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 59) == 0) begin
        #2; reset = 1'b0; m = 0; #1;
        check("rnd_arst_state", db_estado, 0);
        check("rnd_arst_outs", dut_outs, 0);
      end
      rin[6] = ($urandom_range(0, 3) == 0);
      rin[5] = ($urandom_range(0, 2) == 0);
      rin[4] = ($urandom_range(0, 4) == 0);
      rin[3] = ($urandom_range(0, 1) == 0);
      rin[2] = ($urandom_range(0, 2) == 0);
      rin[1] = ($urandom_range(0, 3) != 0);
      rin[0] = ($urandom_range(0, 1) == 0);
      set_in(rin);
      @(posedge clock);
      if (reset) m = nxt(m, rin);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_controle_exp8.md
Name: unidade_controle_exp8

Overview:
- Moore controller that sequences the memory-game datapath. It resets the counters, replays the stored sequence on the LEDs for the current round using the display timer, then collects and checks the player's moves under a per-move timeout.
- It advances rounds and ends the game in win, lose or timeout.
- It sits between the top level and the datapath, driving every counter, register and LED control strobe.

Parameters:
- none (state encoding fixed below; timer lengths live in the datapath)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- iniciar  in  1  start/restart request, level sampled each cycle
- fimT  in  1  display timer at terminal count; timer is modulo and wraps to 0 the cycle after fimT while contaT=1
- fimP  in  1  move-timeout counter at terminal count
- fimRod  in  1  round counter at last round
- jogada  in  1  one-cycle pulse: a button press was detected
- igual  in  1  registered move equals memory word at current address
- enderecoIgualRodada  in  1  address counter equals round counter
- zeraE, contaE  out  1 each  clear / increment address counter
- zeraRod, contaRod  out  1 each  clear / increment round counter
- zeraT, contaT  out  1 each  clear / enable display timer
- zeraP, contaP  out  1 each  clear / enable move-timeout counter
- zeraR, registraR  out  1 each  clear / load move register
- sinal_led  out  1  1 = LEDs show memory word at current address
- pronto  out  1  game finished
- acertou  out  1  game won
- errou  out  1  wrong move
- timeout  out  1  move timeout expired
- db_estado  out  4  current state code

Behaviour:
- Single 4-bit state register; async load of inicial when reset=0. All outputs are pure decodes of state (Moore), so every output is 0 during and right after reset; db_estado=0.
- Unlisted outputs are 0 in each state. Code F is illegal and goes to inicial next cycle.
- States, code : asserted outputs : transitions
  - 0 inicial : none : iniciar -> 1
  - 1 preparacao : zeraE, zeraRod, zeraR, zeraT, zeraP : -> 2
  - 2 inicia_rodada : zeraE, zeraT : -> 3
  - 3 mostra_led : sinal_led, contaT : fimT -> 4, else stay
  - 4 apaga_led : contaT : fimT and enderecoIgualRodada -> 6; fimT and not enderecoIgualRodada -> 5; else stay
  - 5 proximo_led : contaE : -> 3
  - 6 fim_exibicao : zeraE, zeraP, zeraR : -> 7
  - 7 espera_jogada : contaP : jogada -> 8; else fimP -> E; else stay. jogada has priority over a simultaneous fimP.
  - 8 registra : registraR, zeraP : -> 9
  - 9 comparacao : none : see decision order below
  - A proxima_jogada : contaE : -> 7
  - B proxima_rodada : contaRod : -> 2
  - C fim_acertou : pronto, acertou : iniciar -> 1
  - D fim_errou : pronto, errou : iniciar -> 1
  - E fim_timeout : pronto, timeout : iniciar -> 1
- comparacao decision order:
  - not igual -> D
  - igual and enderecoIgualRodada and fimRod -> C
  - igual and enderecoIgualRodada -> B
  - else -> A
- Timing:
  - One LED display period is the timer period; on-phase and off-phase have equal length.
  - Round r (0-based) spends r+1 on/off pairs in states 3/4 before state 6.
- iniciar is ignored in states 1 to B; a restart is accepted only from 0, C, D or E.
- Reset asserted mid-game: immediate return to inicial with all strobes 0, including sinal_led, within the same cycle (async).
- jogada pulses outside state 7 are ignored.

Test Plan:
- Reset: reset=0 with the FSM in state 7 -> db_estado=0 and all outputs 0 asynchronously. Release with iniciar=0 for 5 cycles -> FSM stays in state 0.
- Display sequence, round 0: iniciar pulse -> states 0,1,2,3. With fimT every 4th cycle -> sinal_led high 4 cycles, then state 4 for 4 cycles. enderecoIgualRodada=1 -> 6 then 7.
- Round 2 replay: enderecoIgualRodada high only on the 3rd address -> exactly 3 sinal_led pulses and 2 contaE pulses (state 5) before state 6.
- Correct full game: for each move, jogada then igual=1. Final move has enderecoIgualRodada=1 and fimRod=1 -> state C with pronto=1 and acertou=1. contaRod pulses once per completed non-final round.
- Wrong move: igual=0 in comparacao -> state D, errou=1, pronto=1. Then iniciar=1 -> state 1 with all zera strobes high for one cycle.
- Timeout and priority: fimP=1 alone in state 7 -> state E, timeout=1. Separately, jogada=1 and fimP=1 in the same cycle -> state 8 with registraR=1, not E.
